data_decrypt: RTL and testbench
===============================

// Module: data_decrypt
// PURPOSE
//  Receive-side counterpart of data_encrypt. Descrambles the serial code stream
//  from recursion c[n] = d[n] ^ c[n-3] ^ c[n-5], i.e. d[n] = c[n] ^ c[n-3] ^ c[n-5].
//  Self-synchronises after 5 code bits, hunts for a sync word in the recovered
//  stream, then deserialises WORD_W-bit words MSB-first for the downstream consumer.
// PARAMETERS
//  WORD_W     8       output word width and sync-word width (4..16)
//  SYNC_WORD  8'hA5   sync pattern searched in descrambled stream, MSB-first
// PORTS
//  i_clk         in   1       clock, all logic on rising edge
//  i_rst_n       in   1       reset, asynchronous, active-low
//  i_code        in   1       scrambled serial code bit
//  i_valid       in   1       qualifies i_code; tie 1 when fed directly by data_encrypt
//  i_resync      in   1       force return to HUNT (single-cycle pulse)
//  o_bit         out  1       registered descrambled bit
//  o_bit_valid   out  1       o_bit is meaningful (history full, i.e. state != FILL)
//  o_data        out  WORD_W  last assembled word, MSB = first received bit
//  o_valid       out  1       one-cycle strobe, o_data updated
//  o_locked      out  1       high in state LOCKED
//  o_sync_found  out  1       one-cycle strobe on sync-word match
// BEHAVIOUR
//  Reset (async, i_rst_n=0): history h[4:0]=0, state=FILL, all counters/window=0;
//   o_bit, o_bit_valid, o_data, o_valid, o_locked, o_sync_found all 0.
//  Descrambler: on each edge with i_valid=1: d = i_code ^ h[2] ^ h[4];
//   h <= {h[3:0], i_code} (h[0]=c[n-1], h[2]=c[n-3], h[4]=c[n-5]). i_valid=0: nothing moves.
//   o_bit <= d, o_bit_valid <= (state!=FILL) on that edge; o_bit holds when i_valid=0.
//  FSM (advances only on accepted bits except i_resync):
//   FILL: count 5 accepted bits, bits discarded; 5th bit -> HUNT. i_resync ignored.
//   HUNT: window w <= {w[WORD_W-2:0], d}; hunt count saturates at WORD_W.
//     Match when count (incl. this bit) >= WORD_W and new window == SYNC_WORD:
//     -> LOCKED, o_sync_found=1 next cycle, bit counter=0. Sync word not output.
//   LOCKED: shift d into word register; on WORD_W-th bit: o_data <= completed word,
//     o_valid=1 for the one cycle after that edge, bit counter wraps to 0.
//     Stays LOCKED until i_resync or reset; no sync recheck.
//  i_resync=1 in HUNT/LOCKED: -> HUNT, window/hunt count/bit counter cleared,
//   partial word discarded, any i_valid bit same cycle updates h only (not framed).
//   o_locked=0 the cycle after. o_data keeps last value.
//  Latency: word's last code bit sampled at edge k -> o_data/o_valid valid after edge k.
//  Back-to-back: with i_valid=1 every cycle, o_valid pulses exactly every WORD_W cycles.
//  Error propagation: one flipped code bit corrupts exactly descrambled bits n, n+3, n+5.
//  o_valid, o_sync_found are strobes: never high two consecutive cycles unless WORD_W
//   bits were accepted in between (impossible for WORD_W>1).
//  Reset mid-operation: immediate return to reset values, restart in FILL.
// TESTING
//  T1 reset: assert i_rst_n=0 mid-stream, no clock -> all outputs 0 at once; FILL on release.
//  T2 loopback: data_encrypt->data_decrypt, same clk/reset, i_valid=1; encryptor data =
//   6 zeros, 8'hA5, 8'h3C, 8'hFF (MSB-first) -> o_sync_found once, then o_data=8'h3C,
//   8'hFF each with one o_valid pulse, 8 cycles apart; o_locked=1 from sync to end.
//  T3 gapped valid: same code stream as T2 with i_valid=0 every other cycle -> same
//   o_data sequence 3C, FF; o_valid spacing 16 cycles.
//  T4 error: in T2 after lock flip one code bit inside 8'h3C frame -> exactly 3 decoded
//   bits wrong (positions n, n+3, n+5), later words correct, o_locked stays 1.
//  T5 resync: pulse i_resync after 4 bits of a word -> no o_valid for partial word,
//   o_locked=0 next cycle; resend A5,3C -> relock, o_data=8'h3C.
//  T6 false sync: SYNC_WORD value straddling FILL boundary / within first 7 HUNT bits
//   -> no match until WORD_W bits accumulated in HUNT.

Source files
------------

// File: rtl/data_decrypt.sv
// Self-synchronising descrambler (d = c ^ c[n-3] ^ c[n-5]) with sync-word hunt
// and MSB-first word deserialiser for the receive path of data_encrypt.
module data_decrypt #(
    parameter int unsigned       WORD_W    = 8,
    parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'('hA5)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_code,
    input  logic              i_valid,
    input  logic              i_resync,
    output logic              o_bit,
    output logic              o_bit_valid,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_locked,
    output logic              o_sync_found
);

    localparam int unsigned HIST_W = 5;
    localparam int unsigned FILL_W = 3;
    localparam int unsigned HCNT_W = $clog2(WORD_W + 1);
    localparam int unsigned BCNT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [HIST_W-1:0]   hist_q;
    logic [FILL_W-1:0]   fill_cnt_q;
    logic [HCNT_W-1:0]   hunt_cnt_q;
    logic [BCNT_W-1:0]   bit_cnt_q;
    logic [WORD_W-1:0]   win_q;
    logic [WORD_W-1:0]   word_q;

    logic                d_c;
    logic [WORD_W-1:0]   win_next_c;
    logic                resync_c;
    logic                match_c;
    logic                word_done_c;

    // Next-state and framing decisions for the current accepted bit
    always_comb begin
        state_d     = state_q;
        d_c         = i_code ^ hist_q[2] ^ hist_q[4];
        win_next_c  = {win_q[WORD_W-2:0], d_c};
        resync_c    = i_resync && (state_q != ST_FILL);
        match_c     = 1'b0;
        word_done_c = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (i_valid && (fill_cnt_q == FILL_W'(HIST_W - 1))) begin
                    state_d = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (resync_c) begin
                    state_d = ST_HUNT;
                end else if (i_valid && (hunt_cnt_q >= HCNT_W'(WORD_W - 1)) &&
                             (win_next_c == SYNC_WORD)) begin
                    match_c = 1'b1;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (resync_c) begin
                    state_d = ST_HUNT;
                end else if (i_valid && (bit_cnt_q == BCNT_W'(WORD_W - 1))) begin
                    word_done_c = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Descrambler history, counters, window, word assembly and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist_q       <= '0;
            fill_cnt_q   <= '0;
            hunt_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            win_q        <= '0;
            word_q       <= '0;
            o_bit        <= 1'b0;
            o_bit_valid  <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_locked     <= 1'b0;
            o_sync_found <= 1'b0;
        end else begin
            o_valid      <= word_done_c;
            o_sync_found <= match_c;
            o_locked     <= (state_d == ST_LOCKED);
            if (i_valid) begin
                hist_q      <= {hist_q[HIST_W-2:0], i_code};
                o_bit       <= d_c;
                o_bit_valid <= (state_q != ST_FILL);
            end
            if (word_done_c) begin
                o_data <= {word_q[WORD_W-2:0], d_c};
            end
            // A resync drops all framing; the history keeps tracking the line
            if (resync_c) begin
                win_q      <= '0;
                hunt_cnt_q <= '0;
                bit_cnt_q  <= '0;
                word_q     <= '0;
            end else if (i_valid) begin
                case (state_q)
                    ST_FILL: fill_cnt_q <= fill_cnt_q + FILL_W'(1);
                    ST_HUNT: begin
                        win_q <= win_next_c;
                        if (hunt_cnt_q != HCNT_W'(WORD_W)) begin
                            hunt_cnt_q <= hunt_cnt_q + HCNT_W'(1);
                        end
                        if (match_c) begin
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        word_q    <= {word_q[WORD_W-2:0], d_c};
                        bit_cnt_q <= word_done_c ? '0 : bit_cnt_q + BCNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_decrypt.sv
// Bench for data_decrypt: bit-stream model of the receiver plus directed
// encoder-fed scenarios with hand-computed word expectations.
module tb_data_decrypt;

    localparam int unsigned WORD_W = 8;
    localparam logic [7:0]  SYNC   = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code = 1'b0;
    logic       valid = 1'b0;
    logic       resync = 1'b0;
    logic       o_bit, o_bit_valid, o_valid, o_locked, o_sync_found;
    logic [7:0] o_data;

    always #5 clk = ~clk;

    data_decrypt #(.WORD_W(WORD_W), .SYNC_WORD(SYNC)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_code      (code),
        .i_valid     (valid),
        .i_resync    (resync),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_locked    (o_locked),
        .o_sync_found(o_sync_found)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] q2w(input bit q[$]);
        logic [7:0] w;
        w = '0;
        foreach (q[i]) w = {w[6:0], q[i]};
        return w;
    endfunction

    // Receiver model: whole accepted code stream, recovered bits, framing queues
    bit         cstream[$];
    bit         hunt_q[$];
    bit         word_q[$];
    bit         m_lock = 1'b0;
    logic       m_bit = 1'b0, m_bit_valid = 1'b0, m_valid = 1'b0, m_sync = 1'b0;
    logic [7:0] m_data = '0;
    bit         intended = 1'b0;
    int         bit_errs = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cstream.delete(); hunt_q.delete(); word_q.delete();
            m_lock = 0; m_bit = 0; m_bit_valid = 0; m_valid = 0; m_sync = 0;
            m_data = '0; bit_errs = 0;
        end else begin
            int  n;
            bit  d;
            bit  framed;
            bit  rs_eff;
            rs_eff = resync && (cstream.size() >= 5);
            framed = 1'b0;
            d      = 1'b0;
            m_valid = 0;
            m_sync  = 0;
            if (valid) begin
                cstream.push_back(code);
                n = cstream.size() - 1;
                d = cstream[n];
                if (n >= 3) d ^= cstream[n-3];
                if (n >= 5) d ^= cstream[n-5];
                m_bit = d;
                m_bit_valid = (n >= 5);
                framed = (n >= 5);
                if (framed && d != intended) bit_errs++;
            end
            if (rs_eff) begin
                hunt_q.delete(); word_q.delete(); m_lock = 0;
            end else if (framed) begin
                if (!m_lock) begin
                    hunt_q.push_back(d);
                    if (hunt_q.size() > WORD_W) void'(hunt_q.pop_front());
                    if (hunt_q.size() == WORD_W && q2w(hunt_q) == SYNC) begin
                        m_lock = 1; m_sync = 1;
                    end
                end else begin
                    word_q.push_back(d);
                    if (word_q.size() == WORD_W) begin
                        m_data = q2w(word_q); m_valid = 1; word_q.delete();
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, plus strobe recording
    logic [7:0] words[$];
    int         wcyc[$];
    int         syncs = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            chk("o_bit",        16'(o_bit),        16'(m_bit));
            chk("o_bit_valid",  16'(o_bit_valid),  16'(m_bit_valid));
            chk("o_data",       16'(o_data),       16'(m_data));
            chk("o_valid",      16'(o_valid),      16'(m_valid));
            chk("o_locked",     16'(o_locked),     16'(m_lock));
            chk("o_sync_found", 16'(o_sync_found), 16'(m_sync));
            if (o_valid) begin words.push_back(o_data); wcyc.push_back(cyc); end
            if (o_sync_found) syncs++;
        end
    end

    // Encoder: c = d ^ c[n-3] ^ c[n-5]
    bit enc_hist[$];

    function automatic bit enc(input bit d);
        bit c;
        int s;
        s = enc_hist.size();
        c = d;
        if (s >= 3) c ^= enc_hist[s-3];
        if (s >= 5) c ^= enc_hist[s-5];
        enc_hist.push_back(c);
        return c;
    endfunction

    task automatic send(input bit d, input bit flip);
        code = enc(d) ^ flip;
        intended = d;
        valid = 1'b1;
        resync = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        valid = 1'b0;
        resync = 1'b0;
        code = 1'($urandom);
        @(negedge clk); #1;
    endtask

    task automatic pulse_resync();
        valid = 1'b0;
        resync = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input int flip_idx);
        for (int i = 7; i >= 0; i--) begin
            send(b[i], (7 - i) == flip_idx);
            if (gap) idle();
        end
    endtask

    task automatic clear_rec();
        words.delete(); wcyc.delete(); syncs = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; valid = 1'b0; resync = 1'b0;
        enc_hist.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        clear_rec();
    endtask

    initial begin
        #1;
        do_reset();

        // T2 loopback
        repeat (6) send(1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, -1);
        send_byte(8'h3C, 1'b0, -1);
        send_byte(8'hFF, 1'b0, -1);
        repeat (3) idle();
        chk("t2_syncs",   16'(syncs), 16'd1);
        chk("t2_nwords",  16'(words.size()), 16'd2);
        if (words.size() == 2) begin
            chk("t2_word0",   16'(words[0]), 16'h3C);
            chk("t2_word1",   16'(words[1]), 16'hFF);
            chk("t2_spacing", 16'(wcyc[1] - wcyc[0]), 16'd8);
        end
        chk("t2_locked",  16'(o_locked), 16'd1);

        // T1 asynchronous reset mid-stream, then straddling sync (T6)
        #2 rst_n = 1'b0;
        enc_hist.delete();
        #1;
        chk("t1_outs_zero", 16'({o_bit, o_bit_valid, o_data, o_valid, o_locked, o_sync_found}), 16'd0);
        @(negedge clk); #1;
        chk("t1_held_zero", 16'({o_bit, o_bit_valid, o_data, o_valid, o_locked, o_sync_found}), 16'd0);
        rst_n = 1'b1;
        clear_rec();
        for (int i = 7; i >= 0; i--) begin
            send(SYNC[i], 1'b0);
            if (i == 3) chk("t1_fill_bv0", 16'(o_bit_valid), 16'd0);
            if (i == 2) chk("t1_fill_bv1", 16'(o_bit_valid), 16'd1);
        end
        repeat (12) send(1'b0, 1'b0);
        chk("t6_nosync",  16'(syncs), 16'd0);
        chk("t6_unlock",  16'(o_locked), 16'd0);
        send_byte(8'hA5, 1'b0, -1);
        send_byte(8'h3C, 1'b0, -1);
        repeat (2) idle();
        chk("t6_sync",    16'(syncs), 16'd1);
        chk("t6_nwords",  16'(words.size()), 16'd1);
        if (words.size() == 1) chk("t6_word", 16'(words[0]), 16'h3C);

        // T3 gapped valid
        do_reset();
        for (int i = 0; i < 6; i++) begin send(1'b0, 1'b0); idle(); end
        send_byte(8'hA5, 1'b1, -1);
        send_byte(8'h3C, 1'b1, -1);
        send_byte(8'hFF, 1'b1, -1);
        repeat (4) idle();
        chk("t3_syncs",   16'(syncs), 16'd1);
        chk("t3_nwords",  16'(words.size()), 16'd2);
        if (words.size() == 2) begin
            chk("t3_word0",   16'(words[0]), 16'h3C);
            chk("t3_word1",   16'(words[1]), 16'hFF);
            chk("t3_spacing", 16'(wcyc[1] - wcyc[0]), 16'd16);
        end

        // T4 single code-bit error on the first bit of the 3C frame
        do_reset();
        repeat (6) send(1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, -1);
        send_byte(8'h3C, 1'b0, 0);
        send_byte(8'hFF, 1'b0, -1);
        repeat (3) idle();
        chk("t4_biterrs", 16'(bit_errs), 16'd3);
        chk("t4_nwords",  16'(words.size()), 16'd2);
        if (words.size() == 2) begin
            chk("t4_word0", 16'(words[0]), 16'hA8);
            chk("t4_word1", 16'(words[1]), 16'hFF);
        end
        chk("t4_locked",  16'(o_locked), 16'd1);

        // T5 resync mid-word, then relock
        do_reset();
        repeat (6) send(1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, -1);
        send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        chk("t5_locked_pre", 16'(o_locked), 16'd1);
        pulse_resync();
        chk("t5_unlocked",   16'(o_locked), 16'd0);
        idle();
        chk("t5_no_partial", 16'(words.size()), 16'd0);
        send_byte(8'hA5, 1'b0, -1);
        send_byte(8'h3C, 1'b0, -1);
        repeat (3) idle();
        chk("t5_syncs",  16'(syncs), 16'd2);
        chk("t5_nwords", 16'(words.size()), 16'd1);
        if (words.size() == 1) chk("t5_word", 16'(words[0]), 16'h3C);
        chk("t5_relock", 16'(o_locked), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
